// File: rtl/mmio_console_if.sv
// ---------------------------------------------------------------------------
// mmio_console_if
//   Bundles the CPU data-bus signals and the outgoing byte stream of the
//   memory-mapped console.
//   master : CPU / stream sink side (drives addr, wr_sig, wr_data, tx_ready)
//   slave  : console side (drives sel, rd_data, tx_valid, tx_data)
//   addr     32  CPU data address
//   wr_sig    1  CPU store strobe
//   wr_data  32  CPU store data
//   sel       1  address falls in the console window
//   rd_data  32  read data, zero outside the window
//   tx_valid  1  FIFO head available
//   tx_data   8  FIFO head byte
//   tx_ready  1  sink accepts the head byte
// ---------------------------------------------------------------------------
interface mmio_console_if;
    logic [31:0] addr;
    logic        wr_sig;
    logic [31:0] wr_data;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output addr, wr_sig, wr_data, tx_ready,
        input  sel, rd_data, tx_valid, tx_data
    );

    modport slave (
        input  addr, wr_sig, wr_data, tx_ready,
        output sel, rd_data, tx_valid, tx_data
    );
endinterface

// File: rtl/mmio_console.sv
// ---------------------------------------------------------------------------
// mmio_console
//   Memory-mapped console responder on the CPU data bus. Byte stores to DATA
//   are queued in a first-word-fall-through FIFO and drained on a valid/ready
//   byte stream. STATUS and a popped-byte counter can be polled by software.
//   Register window (16 bytes at BASE_ADDR):
//     0x0 DATA    W: push wr_data[7:0]          R: 0
//     0x4 STATUS  R: {overflow[9], full[8], count[CW-1:0]}
//     0x8 CTRL    W: bit0 clear overflow, bit1 flush   R: 0
//     0xC TXCOUNT R: bytes popped since reset (wrapping)
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    slave modport of mmio_console_if (CPU bus + byte stream)
// ---------------------------------------------------------------------------
module mmio_console #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 16
) (
    input  logic            clk,
    input  logic            reset,
    mmio_console_if.slave   bus
);

    localparam int             CW         = $clog2(DEPTH + 1);
    localparam int             AW         = $clog2(DEPTH);
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_txCount;

    logic          w_sel;
    logic [1:0]    w_offset;
    logic          w_push;
    logic          w_ctrlWr;
    logic          w_flush;
    logic          w_clrOvf;
    logic          w_full;
    logic          w_valid;
    logic          w_pop;
    logic          w_accept;
    logic [31:0]   w_status;

    // Address decode and per-cycle push/pop qualification. A push into a full
    // FIFO is still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        w_sel    = (bus.addr[31:4] == BASE_ADDR[31:4]);
        w_offset = bus.addr[3:2];
        w_push   = bus.wr_sig && w_sel && (w_offset == 2'd0);
        w_ctrlWr = bus.wr_sig && w_sel && (w_offset == 2'd2);
        w_flush  = w_ctrlWr && bus.wr_data[1];
        w_clrOvf = w_ctrlWr && bus.wr_data[0];
        w_full   = (r_count == FULL_COUNT);
        w_valid  = (r_count != '0);
        w_pop    = w_valid && bus.tx_ready;
        w_accept = w_push && (!w_full || w_pop);
    end

    // FIFO bookkeeping, overflow flag and popped-byte counter. Flush pre-empts
    // a same-cycle pop, so the discarded head byte is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_txCount  <= '0;
        end else begin
            if (w_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_accept) begin
                    r_wrPtr <= r_wrPtr + AW'(1);
                end
                if (w_pop) begin
                    r_rdPtr   <= r_rdPtr + AW'(1);
                    r_txCount <= r_txCount + 32'd1;
                end
                if (w_accept && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_accept && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
            if (w_clrOvf) begin
                r_overflow <= 1'b0;
            end else if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Byte storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= bus.wr_data[7:0];
        end
    end

    // Read mux and stream outputs, all combinational from address and state.
    always_comb begin
        w_status              = '0;
        w_status[CW-1:0]      = r_count;
        w_status[8]           = w_full;
        w_status[9]           = r_overflow;
        bus.sel               = w_sel;
        bus.rd_data           = '0;
        if (w_sel) begin
            case (w_offset)
                2'd1:    bus.rd_data = w_status;
                2'd3:    bus.rd_data = r_txCount;
                default: bus.rd_data = '0;
            endcase
        end
        bus.tx_valid = w_valid;
        bus.tx_data  = r_mem[r_rdPtr];
    end

endmodule

// File: tb/tb_mmio_console.sv
// ---------------------------------------------------------------------------
// tb_mmio_console
//   Self-checking bench for mmio_console: a table of single-cycle vectors for
//   reset, decode and ordering, then hand-written sequences for overflow,
//   full-with-simultaneous-pop, flush, counter wrap and reset mid-drain.
// ---------------------------------------------------------------------------
module tb_mmio_console;

    logic clk;
    logic reset;
    int   passCount;
    int   checkCount;

    mmio_console_if bus ();

    mmio_console #(
        .BASE_ADDR (32'h0000_1000),
        .DEPTH     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        rdy;
        logic        expSel;
        logic [31:0] expRd;
        logic        expValid;
        logic [7:0]  expData;
        logic        chkData;
    } vec_t;

    vec_t vecs [15];

    // Inputs change only at the falling edge so they are stable at posedge.
    task automatic applyStimulus(input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input logic r);
        bus.addr     = a;
        bus.wr_sig   = w;
        bus.wr_data  = d;
        bus.tx_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic readCheck(input string name, input logic [31:0] a,
                             input logic [31:0] exp);
        bus.addr   = a;
        bus.wr_sig = 1'b0;
        #1;
        checkOutput(name, bus.rd_data, exp);
    endtask

    task automatic cpuStore(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(a, 1'b1, d, bus.tx_ready);
        tick();
        bus.wr_sig = 1'b0;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        applyStimulus(32'h0000_1000, 1'b0, 32'h0, 1'b0);

        //              addr          wr    wdata   rdy  sel   rd        vld   data   chk
        vecs[0]  = '{32'h0000_1000, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[1]  = '{32'h0000_1004, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[2]  = '{32'h0000_1008, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[3]  = '{32'h0000_100C, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[4]  = '{32'h0000_2000, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[5]  = '{32'h0000_2000, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[6]  = '{32'h0000_1000, 1'b1, 32'h41, 1'b0, 1'b1, 32'h0,    1'b0, 8'h00, 1'b0};
        vecs[7]  = '{32'h0000_1000, 1'b1, 32'h42, 1'b0, 1'b1, 32'h0,    1'b1, 8'h41, 1'b1};
        vecs[8]  = '{32'h0000_1000, 1'b1, 32'h43, 1'b0, 1'b1, 32'h0,    1'b1, 8'h41, 1'b1};
        vecs[9]  = '{32'h0000_1004, 1'b0, 32'h0,  1'b0, 1'b1, 32'h3,    1'b1, 8'h41, 1'b1};
        vecs[10] = '{32'h0000_1004, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3,    1'b1, 8'h41, 1'b1};
        vecs[11] = '{32'h0000_1004, 1'b0, 32'h0,  1'b1, 1'b1, 32'h2,    1'b1, 8'h42, 1'b1};
        vecs[12] = '{32'h0000_1004, 1'b0, 32'h0,  1'b1, 1'b1, 32'h1,    1'b1, 8'h43, 1'b1};
        vecs[13] = '{32'h0000_100C, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3,    1'b0, 8'h00, 1'b0};
        vecs[14] = '{32'h0000_1004, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 8'h00, 1'b0};

        // Reset held for two rising edges.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, decode and ordering from the vector table.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rdy);
            #1;
            checkOutput($sformatf("v%0d.sel", i), 32'(bus.sel), 32'(vecs[i].expSel));
            checkOutput($sformatf("v%0d.rd_data", i), bus.rd_data, vecs[i].expRd);
            checkOutput($sformatf("v%0d.tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].expValid));
            if (vecs[i].chkData) begin
                checkOutput($sformatf("v%0d.tx_data", i), 32'(bus.tx_data), 32'(vecs[i].expData));
            end
            tick();
        end

        // Overflow: 17 stores with the sink stalled, 0x10 is dropped.
        applyStimulus(32'h0000_1000, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            cpuStore(32'h0000_1000, 32'(i));
        end
        readCheck("ovf.status", 32'h0000_1004, 32'h0000_0310);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checkOutput($sformatf("ovf.data%0d", i), {23'b0, bus.tx_valid, bus.tx_data},
                        {23'b0, 1'b1, 8'(i)});
            tick();
        end
        bus.tx_ready = 1'b0;
        #1;
        checkOutput("ovf.drained", 32'(bus.tx_valid), 32'h0);
        readCheck("ovf.txcount", 32'h0000_100C, 32'd19);
        cpuStore(32'h0000_1008, 32'h1);
        readCheck("ovf.cleared", 32'h0000_1004, 32'h0);

        // Full FIFO with a push and a pop in the same cycle.
        for (int i = 0; i < 16; i++) begin
            cpuStore(32'h0000_1000, 32'h80 + 32'(i));
        end
        readCheck("full.status", 32'h0000_1004, 32'h0000_0110);
        applyStimulus(32'h0000_1000, 1'b1, 32'hAA, 1'b1);
        tick();
        applyStimulus(32'h0000_1004, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("full.simul.status", bus.rd_data, 32'h0000_0110);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checkOutput($sformatf("full.data%0d", i), {23'b0, bus.tx_valid, bus.tx_data},
                        {23'b0, 1'b1, (i == 15) ? 8'hAA : 8'(8'h81 + i)});
            tick();
        end
        bus.tx_ready = 1'b0;
        readCheck("full.txcount", 32'h0000_100C, 32'd36);

        // Flush with the sink ready in the same cycle: nothing is counted.
        for (int i = 0; i < 5; i++) begin
            cpuStore(32'h0000_1000, 32'h11 + 32'(i));
        end
        readCheck("flush.pre", 32'h0000_1004, 32'd5);
        applyStimulus(32'h0000_1008, 1'b1, 32'h2, 1'b1);
        tick();
        applyStimulus(32'h0000_1004, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("flush.valid", 32'(bus.tx_valid), 32'h0);
        readCheck("flush.status", 32'h0000_1004, 32'h0);
        readCheck("flush.txcount", 32'h0000_100C, 32'd36);

        // TXCOUNT wrap from all-ones to zero on one pop.
        cpuStore(32'h0000_1000, 32'h77);
        force dut.r_txCount = 32'hFFFF_FFFF;
        #1;
        release dut.r_txCount;
        readCheck("wrap.preload", 32'h0000_100C, 32'hFFFF_FFFF);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        readCheck("wrap.txcount", 32'h0000_100C, 32'h0);

        // Reset in the middle of a drain discards the queue and the counter.
        for (int i = 0; i < 8; i++) begin
            cpuStore(32'h0000_1000, 32'h30 + 32'(i));
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("rst.data%0d", i), 32'(bus.tx_data), 32'h30 + 32'(i));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.tx_ready = 1'b0;
        #1;
        checkOutput("rst.valid", 32'(bus.tx_valid), 32'h0);
        readCheck("rst.status", 32'h0000_1004, 32'h0);
        readCheck("rst.txcount", 32'h0000_100C, 32'h0);
        cpuStore(32'h0000_1000, 32'h5A);
        #1;
        checkOutput("rst.after", {23'b0, bus.tx_valid, bus.tx_data}, {23'b0, 1'b1, 8'h5A});
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        #1;
        checkOutput("rst.after.valid", 32'(bus.tx_valid), 32'h0);
        readCheck("rst.after.txcount", 32'h0000_100C, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
